// File: rtl/instr_encoder.sv
// instr_encoder: packs ALU operation tuples into 16-bit machine words
// {opcode, dst, imm|regb, rega}. Words go into a small FIFO that feeds a
// valid/ready consumer. Tuples that have no legal encoding are dropped and
// counted.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       OpALU,
  input  logic             isImm,
  input  logic [3:0]       OpC,
  input  logic [3:0]       OpB,
  input  logic [3:0]       OpA,
  output logic [15:0]      Instr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             ErrPulse,
  output logic [CNT_W-1:0] EncCnt,
  output logic [CNT_W-1:0] ErrCnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_C  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_next;
  logic [4:0]       enc;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;

  // Maps (alu op, immediate flag) to {legal, opcode}; anything unlisted is illegal.
  function automatic logic [4:0] encode(input logic [3:0] op, input logic imm);
    logic [4:0] r;
    case ({op, imm})
      5'b0000_0: r = 5'b1_0000;  // ADD reg
      5'b0001_0: r = 5'b1_0001;  // SUB reg
      5'b0010_1: r = 5'b1_0010;  // SLT imm
      5'b0011_0: r = 5'b1_0011;  // AND reg
      5'b0100_0: r = 5'b1_0100;  // OR  reg
      5'b0101_0: r = 5'b1_0101;  // XOR reg
      5'b0011_1: r = 5'b1_0110;  // AND imm
      5'b0100_1: r = 5'b1_0111;  // OR  imm
      5'b0101_1: r = 5'b1_1000;  // XOR imm
      5'b0000_1: r = 5'b1_1001;  // ADD imm
      5'b0001_1: r = 5'b1_1010;  // SUB imm
      default:   r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign enc      = encode(OpALU, isImm);
  assign legal    = enc[4];
  assign accept   = InValid && InReady;
  assign push     = accept && legal;
  assign OutValid = (count != '0);
  assign pop      = OutValid && OutReady;
  assign Instr    = OutValid ? mem[rd_ptr] : 16'h0000;

  // Next occupancy; a push is only possible when not full, so no overflow.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Storage array is not reset; the occupancy count gates it from the output.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {enc[3:0], OpC, OpB, OpA};
  end

  // Pointers, occupancy, registered ready, error pulse and statistics.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      InReady  <= 1'b0;
      ErrPulse <= 1'b0;
      EncCnt   <= '0;
      ErrCnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count    <= count_next;
      // Ready follows occupancy one cycle late, so a pop while full
      // frees a slot only from the next cycle on.
      InReady  <= (count_next < FULL_C);
      ErrPulse <= accept && !legal;
      if (push)            EncCnt <= sat_inc(EncCnt);
      if (accept && !legal) ErrCnt <= sat_inc(ErrCnt);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a table of single-tuple vectors plus
// hand-written multi-cycle sequences, checked against a queue model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             CLK;
  logic             RST_N;
  logic             InValid;
  logic             InReady;
  logic [3:0]       OpALU;
  logic             isImm;
  logic [3:0]       OpC;
  logic [3:0]       OpB;
  logic [3:0]       OpA;
  logic [15:0]      Instr;
  logic             OutValid;
  logic             OutReady;
  logic             ErrPulse;
  logic [CNT_W-1:0] EncCnt;
  logic [CNT_W-1:0] ErrCnt;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .InValid(InValid), .InReady(InReady),
    .OpALU(OpALU), .isImm(isImm), .OpC(OpC), .OpB(OpB), .OpA(OpA),
    .Instr(Instr), .OutValid(OutValid), .OutReady(OutReady),
    .ErrPulse(ErrPulse), .EncCnt(EncCnt), .ErrCnt(ErrCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [15:0] exp_q[$];
  int          m_enc = 0;
  int          m_err = 0;
  bit          m_rdy = 0;
  bit          m_pulse = 0;

  typedef struct {
    logic [3:0]  op;
    logic        imm;
    logic [3:0]  c, b, a;
    logic [15:0] exp;
    bit          legal;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [3:0] op, input logic imm,
                              input logic [3:0] c, input logic [3:0] b,
                              input logic [3:0] a, input logic [15:0] exp,
                              input bit legal);
    vec_t v;
    v.op = op; v.imm = imm; v.c = c; v.b = b; v.a = a; v.exp = exp; v.legal = legal;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic imm, input logic [3:0] c,
                       input logic [3:0] b, input logic [3:0] a);
    InValid = 1'b1; OpALU = op; isImm = imm; OpC = c; OpB = b; OpA = a;
  endtask

  // One clock: check outputs against the model before the edge, then
  // advance the model by the handshakes the DUT performed.
  task automatic step(input logic [15:0] exp_word, input bit legal);
    bit push, pop;
    check("out_valid", OutValid, (exp_q.size() != 0));
    check("instr", Instr, (exp_q.size() != 0) ? exp_q[0] : 16'h0000);
    check("in_ready", InReady, m_rdy);
    push = InValid && InReady;
    pop  = OutValid && OutReady;
    @(posedge CLK);
    if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
    if (push && legal) begin
      exp_q.push_back(exp_word);
      if (m_enc < 255) m_enc++;
    end
    if (push && !legal && m_err < 255) m_err++;
    m_pulse = push && !legal;
    m_rdy = (exp_q.size() < DEPTH);
    #1;
    check("err_pulse", ErrPulse, m_pulse);
    check("enc_cnt", EncCnt, m_enc);
    check("err_cnt", ErrCnt, m_err);
  endtask

  task automatic idle();
    InValid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, timeout %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, g, drained;
    logic [15:0] w [5];
    logic [3:0]  kk;

    vecs[0]  = mk(4'h0, 1'b0, 4'h4, 4'h3, 4'h2, 16'h0432, 1);
    vecs[1]  = mk(4'h1, 1'b1, 4'h1, 4'hF, 4'h0, 16'hA1F0, 1);
    vecs[2]  = mk(4'h2, 1'b1, 4'h5, 4'h7, 4'h3, 16'h2573, 1);
    vecs[3]  = mk(4'h2, 1'b0, 4'h1, 4'h2, 4'h3, 16'h0000, 0);
    vecs[4]  = mk(4'h9, 1'b0, 4'h6, 4'h6, 4'h6, 16'h0000, 0);
    vecs[5]  = mk(4'h1, 1'b0, 4'h7, 4'h8, 4'h9, 16'h1789, 1);
    vecs[6]  = mk(4'h3, 1'b0, 4'hA, 4'hB, 4'hC, 16'h3ABC, 1);
    vecs[7]  = mk(4'h4, 1'b0, 4'h0, 4'h1, 4'h2, 16'h4012, 1);
    vecs[8]  = mk(4'h5, 1'b0, 4'hF, 4'hE, 4'hD, 16'h5FED, 1);
    vecs[9]  = mk(4'h3, 1'b1, 4'h2, 4'h4, 4'h6, 16'h6246, 1);
    vecs[10] = mk(4'h4, 1'b1, 4'h3, 4'h5, 4'h7, 16'h7357, 1);
    vecs[11] = mk(4'h5, 1'b1, 4'h8, 4'h9, 4'hA, 16'h889A, 1);
    vecs[12] = mk(4'h0, 1'b1, 4'hC, 4'hD, 4'hE, 16'h9CDE, 1);
    vecs[13] = mk(4'h6, 1'b1, 4'h1, 4'h1, 4'h1, 16'h0000, 0);
    vecs[14] = mk(4'hF, 1'b0, 4'h2, 4'h2, 4'h2, 16'h0000, 0);

    // Reset state
    RST_N = 1'b0; InValid = 1'b0; OpALU = '0; isImm = 1'b0;
    OpC = '0; OpB = '0; OpA = '0; OutReady = 1'b1;
    #1;
    check("rst_in_ready", InReady, 0);
    check("rst_out_valid", OutValid, 0);
    check("rst_instr", Instr, 16'h0000);
    check("rst_err_pulse", ErrPulse, 0);
    check("rst_enc_cnt", EncCnt, 0);
    check("rst_err_cnt", ErrCnt, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_hold_in_ready", InReady, 0);
    RST_N = 1'b1;
    step(16'h0, 0);
    check("in_ready_after_release", InReady, 1);

    // Table: each tuple into an empty FIFO, then one idle cycle to drain it
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].imm, vecs[i].c, vecs[i].b, vecs[i].a);
      step(vecs[i].exp, vecs[i].legal);
      if (vecs[i].legal) begin
        check($sformatf("vec%0d_instr", i), Instr, vecs[i].exp);
        check($sformatf("vec%0d_valid", i), OutValid, 1);
      end else begin
        check($sformatf("vec%0d_pulse", i), ErrPulse, 1);
        check($sformatf("vec%0d_empty", i), OutValid, 0);
      end
      idle();
      step(16'h0, 0);
    end

    // Fill to full while stalled; the fifth word waits for the first pop
    OutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      kk = 4'(i);
      w[i] = {4'h4, kk, kk + 4'h1, kk + 4'h2};
    end
    k = 0; g = 0;
    while (k < 5 && g < 40) begin
      kk = 4'(k);
      drive(4'h4, 1'b0, kk, kk + 4'h1, kk + 4'h2);
      if (k == 4 && g == 4) check("full_in_ready", InReady, 0);
      if (g == 7) OutReady = 1'b1;
      if (InReady) begin
        step(w[k], 1);
        k++;
      end else begin
        step(w[k], 1);
        if (OutReady == 1'b0) check("stall_instr", Instr, w[0]);
      end
      g++;
    end
    check("fifth_accepted", k, 5);
    idle();
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      step(16'h0, 0);
      g++;
    end
    check("drain_done", OutValid, 0);

    // Steady occupancy of 2 with simultaneous push/pop, pointers wrap
    OutReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      kk = 4'(i);
      drive(4'h1, 1'b0, kk, 4'hE, kk);
      step({4'h1, kk, 4'hE, kk}, 1);
    end
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      kk = 4'(i + 2);
      drive(4'h3, 1'b1, kk, 4'h5, ~kk);
      step({4'h6, kk, 4'h5, ~kk}, 1);
    end
    idle();
    drained = 0; g = 0;
    while (OutValid && g < 10) begin
      step(16'h0, 0);
      drained++;
      g++;
    end
    check("steady_occupancy", drained, 2);

    // Counter saturation
    for (int i = 0; i < 260; i++) begin
      drive(4'h0, 1'b1, 4'h1, 4'h2, 4'h3);
      step(16'h9123, 1);
    end
    for (int i = 0; i < 260; i++) begin
      drive(4'h7, 1'b0, 4'h1, 4'h2, 4'h3);
      step(16'h0, 0);
    end
    idle();
    step(16'h0, 0);
    check("enc_saturated", EncCnt, 8'hFF);
    check("err_saturated", ErrCnt, 8'hFF);

    // Asynchronous reset with 3 words buffered
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kk = 4'(i);
      drive(4'h5, 1'b0, kk, kk, kk);
      step({4'h5, kk, kk, kk}, 1);
    end
    idle();
    check("pre_reset_valid", OutValid, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_out_valid", OutValid, 0);
    check("async_instr", Instr, 16'h0000);
    check("async_enc_cnt", EncCnt, 0);
    check("async_err_cnt", ErrCnt, 0);
    check("async_in_ready", InReady, 0);
    exp_q.delete();
    m_enc = 0; m_err = 0; m_rdy = 0; m_pulse = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    OutReady = 1'b1;
    step(16'h0, 0);
    drive(4'h0, 1'b0, 4'h4, 4'h3, 4'h2);
    step(16'h0432, 1);
    check("post_reset_instr", Instr, 16'h0432);
    check("post_reset_enc", EncCnt, 1);
    idle();
    step(16'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Takes ALU-level operation tuples (ALU op, immediate flag, three 4-bit operand fields) and encodes them into 16-bit machine words of the form INSTR DST, IMM|REGB, REGA.
- Encoded words are buffered in a small FIFO and presented on a valid/ready output toward the instruction memory loader / test program generator.
- Tuples with no legal encoding are rejected and counted.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, >= 2).
- CNT_W, 8, width of the saturating statistics counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- InValid  in  1  input tuple valid.
- InReady  out  1  encoder can accept a tuple.
- OpALU  in  4  ALU operation code: ADD=0, SUB=1, SLT=2, AND=3, OR=4, XOR=5.
- isImm  in  1  1 = immediate form (OpB carries imm).
- OpC  in  4  destination register field.
- OpB  in  4  REGB or immediate field.
- OpA  in  4  REGA field.
- Instr  out  16  encoded word at FIFO head.
- OutValid  out  1  Instr is valid.
- OutReady  in  1  consumer accepts Instr.
- ErrPulse  out  1  one-cycle pulse: last accepted tuple was illegal.
- EncCnt  out  CNT_W  number of words encoded, saturating.
- ErrCnt  out  CNT_W  number of tuples rejected, saturating.

Behaviour:
- Reset (RST_N low, asynchronous): FIFO emptied, InReady=0 while asserted, OutValid=0, Instr=16'h0000, ErrPulse=0, EncCnt=0, ErrCnt=0. Reset mid-transfer discards all buffered words. InReady returns to 1 on the first CLK edge after release.
- Accept occurs when InValid && InReady on a rising CLK edge. InReady = (occupancy < DEPTH), registered. There is no same-cycle pass-through when full: a pop while full does not raise InReady in that same cycle.
- Encoding of (OpALU, isImm) to opcode Instr[15:12]:
  - ADD/0 -> 0000; SUB/0 -> 0001; SLT/1 -> 0010; AND/0 -> 0011; OR/0 -> 0100; XOR/0 -> 0101.
  - AND/1 -> 0110; OR/1 -> 0111; XOR/1 -> 1000; ADD/1 -> 1001; SUB/1 -> 1010.
- Word format: Instr = {opcode, OpC, OpB, OpA}, with fields passed through unchanged.
- Illegal tuples: SLT with isImm=0, or OpALU > 5.
  - The tuple is consumed by the handshake but not written to the FIFO.
  - ErrPulse=1 in the following cycle for exactly one cycle.
  - ErrCnt increments.
- Legal tuples: written at the tail. EncCnt increments on the accept edge.
- Both counters saturate at 2^CNT_W-1 with no wrap.
- Output handshake:
  - OutValid = occupancy != 0. Instr always shows the head entry, or 16'h0000 when empty.
  - Pop on OutValid && OutReady.
  - Instr and OutValid hold stable while OutValid && !OutReady.
- Latency: a legal tuple accepted into an empty FIFO appears on Instr/OutValid in the next cycle.
- Simultaneous push and pop with occupancy in 1..DEPTH-1: occupancy unchanged, order preserved.
- Simultaneous illegal accept and pop: pop only, ErrPulse next cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked with log2(DEPTH)+1 bits.
- OutReady while empty has no effect.

Test Plan:
1. Reset, then push ADD/0 with OpC=4, OpB=3, OpA=2, OutReady=1 -> next cycle Instr=16'h0432, OutValid=1; EncCnt=1.
2. Push SUB/1 with OpC=1, OpB=F, OpA=0 -> Instr=16'hA1F0. Push SLT/1 with OpC=5, OpB=7, OpA=3 -> Instr=16'h2573.
3. Push SLT/0, then OpALU=4'h9 -> neither enqueued; two ErrPulse single-cycle pulses; ErrCnt=2; EncCnt unchanged.
4. OutReady=0, push 5 legal words with DEPTH=4 -> InReady=0 after the 4th accept, 5th held. Release OutReady -> words drain in order, 5th accepted after the first pop, Instr stable while stalled.
5. Keep FIFO at occupancy 2 with continuous push and pop for 10 cycles -> occupancy constant at 2, all 10 words emerge in order, pointer wrap exercised.
6. Assert RST_N low mid-stream with 3 words buffered -> OutValid=0 and Instr=16'h0000 immediately (asynchronous); counters=0; first post-reset push encodes correctly.
